hilo_muldiv_ctrl: RTL
=====================

Name: hilo_muldiv_ctrl

Overview:
Multi-cycle sequencer for the HI/LO register pair in the pipelined MIPS datapath. It accepts multiply, divide and move-to-HI/LO operations from EX, computes the result over several cycles, and issues the one-cycle write strobes and data into the HI/LO register. It raises a stall to the hazard unit while HI/LO is in flight, so MFHI/MFLO and back-to-back HI/LO operations never see stale data.

Parameters:
MUL_CYCLES, 4, cycles from Start to write strobe for MULT/MULTU/MADD/MSUB; legal range 1..16.
DIV_CYCLES, 32, iteration cycles of the radix-2 restoring divider; fixed at the data width.

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  synchronous reset, active-high
Start  in  1  EX stage presents a HI/LO operation this cycle
Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
RsData  in  32  operand A / dividend / MT source
RtData  in  32  operand B / divisor
HI  in  32  current HI register value
LO  in  32  current LO register value
Cancel  in  1  flush of the owning instruction; abort without writing
ReadReq  in  1  ID stage holds MFHI/MFLO
inHigh  out  32  write data to HI
inLow  out  32  write data to LO
HIWrite  out  1  HI write strobe
LOWrite  out  1  LO write strobe
Busy  out  1  operation accepted and not yet written
Done  out  1  one-cycle pulse coincident with the write strobes
Stall  out  1  hold ID/EX

Behaviour:
- Reset: Clk rising edge, Rst synchronous, active-high. On reset: state=IDLE; inHigh=inLow=0; HIWrite=LOWrite=Busy=Done=0; counter=0. Rst overrides Start and Cancel, including mid-operation. Any in-flight op is dropped and no write is issued.
- Registered outputs: inHigh, inLow, HIWrite, LOWrite and Done are registered. Strobes are high for exactly one cycle, the WB cycle.
- Start acceptance: Start is accepted only when Busy=0 and Cancel=0. Operands, Op, HI and LO are captured at the accepting edge. Start while Busy=1 is ignored and stalled.
- States: IDLE, MUL, DIV, FIX, WB.
  - IDLE: on accepted Start go to MUL (Op 000/001/110/111), DIV (010/011), or WB (100/101).
  - MUL: count MUL_CYCLES-1 cycles, then go to WB.
  - DIV: 32 iterations, then FIX, then WB.
  - WB: return to IDLE. Start is not accepted in WB (Busy=1).
- Latency, with Start accepted in cycle N:
  - MTHI/MTLO: strobe in cycle N+1.
  - MUL ops: strobe in cycle N+MUL_CYCLES.
  - DIV ops: strobe in cycle N+DIV_CYCLES+2.
- Busy: high from cycle N+1 through the WB cycle inclusive.
- MTHI: HIWrite=1, inHigh=Rs, LOWrite=0. MTLO: LOWrite=1, inLow=Rs, HIWrite=0.
- MULT/MULTU: 64-bit product, signed or unsigned; {inHigh,inLow}=product; both strobes asserted.
- DIV/DIVU datapath: operates on magnitudes (signed ops) or raw values (unsigned).
  - FIX cycle: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Result: LO=quotient, HI=remainder; both strobes asserted.
- DIV boundary cases:
  - Divisor 0: LO=32'hFFFFFFFF, HI=Rs. Full latency is kept.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Stall = Busy & (ReadReq | Start). MFHI/MFLO in the WB cycle stalls; the read proceeds in the next cycle, after HI/LO has updated.
- Cancel:
  - While Busy (MUL/DIV/FIX states): next state is IDLE, Busy drops next cycle, no strobes.
  - In WB: ignored, and the write completes.
  - In IDLE: the same-cycle Start is rejected.

Optional Feature:
HILO_MADD_EN.
- Defined: MADD computes {HI,LO}+signed(Rs*Rt) and MSUB computes {HI,LO}-signed(Rs*Rt), using the HI/LO values captured at Start. Both use MUL_CYCLES latency and assert both strobes. The result wraps modulo 2^64.
- Undefined: Op 110/111 are accepted as no-ops. The block goes straight to IDLE with no Busy, no strobes and no stall.

Test Plan:
- Reset mid-DIV: start DIV 100/7, assert Rst at cycle N+10 -> next cycle Busy=0, HIWrite=LOWrite=0; no strobe ever follows.
- MULT -3*5, MUL_CYCLES=4, Start in cycle 0 -> cycle 4: HIWrite=LOWrite=Done=1, inHigh=0xFFFFFFFF, inLow=0xFFFFFFF1; Busy high cycles 1-4.
- DIV -7/2 and DIVU 7/0 -> strobes in cycle 34 with LO=0xFFFFFFFD, HI=0xFFFFFFFF; then LO=0xFFFFFFFF, HI=7.
- MTLO 0x1234 with ReadReq held -> LOWrite=1 and inLow=0x1234 in cycle 1, HIWrite=0; Stall=1 in cycle 1 only.
- Start MULT, Cancel at cycle 2, new Start at cycle 2 -> Busy=0 in cycle 3, no strobes, second Start ignored; Start at cycle 3 accepted.
- HILO_MADD_EN defined: HI=0, LO=0xFFFFFFFF, MADD 1*1 -> inHigh=1, inLow=0 after MUL_CYCLES. Undefined: same stimulus -> no strobes, Busy stays 0.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multi-cycle sequencer: MULT/MULTU/DIV/DIVU/MTHI/MTLO, with MADD/MSUB when
// HILO_MADD_EN is defined (otherwise Op 110/111 are accepted as no-ops).
module hilo_muldiv_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic [31:0] HI,
  input  logic [31:0] LO,
  input  logic        Cancel,
  input  logic        ReadReq,
  output logic [31:0] inHigh,
  output logic [31:0] inLow,
  output logic        HIWrite,
  output logic        LOWrite,
  output logic        Busy,
  output logic        Done,
  output logic        Stall
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_WB} state_t;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic c);
    return c ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return neg_if(v, is_signed & v[31]);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [31:0] in_high_q, in_high_d, in_low_q, in_low_d;
  logic        hi_wr_q, hi_wr_d, lo_wr_q, lo_wr_d, done_q, done_d;

  logic        idle, accept, is_mul_op, is_div_op;
  logic [2:0]  op_sel;
  logic [31:0] a_sel, b_sel;
  logic        mul_signed;
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] prod;
  logic [63:0] mul_res;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic        div_signed;
  logic [31:0] quo_fix, rem_fix;
  logic        unused_bits;

  assign idle      = (state_q == S_IDLE);
  assign accept    = Start & ~Cancel & idle;
  assign is_div_op = (Op == OP_DIV) | (Op == OP_DIVU);

  // In IDLE the operands come straight from EX so a single-cycle multiply still works.
  assign op_sel = idle ? Op     : op_q;
  assign a_sel  = idle ? RsData : a_q;
  assign b_sel  = idle ? RtData : b_q;

  assign mul_signed = (op_sel != OP_MULTU);
  assign mul_a      = $signed({mul_signed & a_sel[31], a_sel});
  assign mul_b      = $signed({mul_signed & b_sel[31], b_sel});
  assign prod       = mul_a * mul_b;

`ifdef HILO_MADD_EN
  logic [31:0] hi_q, lo_q;
  logic [63:0] acc_sel;

  always_ff @(posedge Clk) begin
    if (accept) begin
      hi_q <= HI;
      lo_q <= LO;
    end
  end

  assign acc_sel   = idle ? {HI, LO} : {hi_q, lo_q};
  assign is_mul_op = (Op == OP_MULT) | (Op == OP_MULTU) | (Op == OP_MADD) | (Op == OP_MSUB);

  always_comb begin
    mul_res = prod[63:0];
    if (op_sel == OP_MADD)      mul_res = acc_sel + prod[63:0];
    else if (op_sel == OP_MSUB) mul_res = acc_sel - prod[63:0];
  end

  assign unused_bits = ^{prod[65:64], trial[32]};
`else
  assign is_mul_op   = (Op == OP_MULT) | (Op == OP_MULTU);
  assign mul_res     = prod[63:0];
  assign unused_bits = ^{prod[65:64], trial[32], HI, LO, OP_MADD, OP_MSUB};
`endif

  // Restoring divider step on magnitudes; the remainder stays below the divisor.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

  assign div_signed = (op_q == OP_DIV);
  always_comb begin
    quo_fix = neg_if(quo_q, div_signed & (a_q[31] ^ b_q[31]));
    rem_fix = neg_if(rem_q, div_signed & a_q[31]);
    if (b_q == 32'd0) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = a_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul_op)                            state_d = (MUL_CYCLES == 1) ? S_WB : S_MUL;
          else if (is_div_op)                       state_d = S_DIV;
          else if ((Op == OP_MTHI) | (Op == OP_MTLO)) state_d = S_WB;
        end
      end
      S_MUL:   if (Cancel) state_d = S_IDLE; else if (cnt_q == 6'd1) state_d = S_WB;
      S_DIV:   if (Cancel) state_d = S_IDLE; else if (cnt_q == 6'd1) state_d = S_FIX;
      S_FIX:   state_d = Cancel ? S_IDLE : S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hi_wr_d   = 1'b0;
    lo_wr_d   = 1'b0;
    done_d    = 1'b0;
    in_high_d = in_high_q;
    in_low_d  = in_low_q;
    if (state_d == S_WB) begin
      done_d = 1'b1;
      if (state_q == S_FIX) begin
        hi_wr_d   = 1'b1;
        lo_wr_d   = 1'b1;
        in_high_d = rem_fix;
        in_low_d  = quo_fix;
      end else if (op_sel == OP_MTHI) begin
        hi_wr_d   = 1'b1;
        in_high_d = a_sel;
      end else if (op_sel == OP_MTLO) begin
        lo_wr_d   = 1'b1;
        in_low_d  = a_sel;
      end else begin
        hi_wr_d   = 1'b1;
        lo_wr_d   = 1'b1;
        in_high_d = mul_res[63:32];
        in_low_d  = mul_res[31:0];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q     <= '0;
      hi_wr_q   <= 1'b0;
      lo_wr_q   <= 1'b0;
      done_q    <= 1'b0;
      in_high_q <= '0;
      in_low_q  <= '0;
    end else begin
      hi_wr_q   <= hi_wr_d;
      lo_wr_q   <= lo_wr_d;
      done_q    <= done_d;
      in_high_q <= in_high_d;
      in_low_q  <= in_low_d;
      if (accept)                                   cnt_q <= is_div_op ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES - 1);
      else if ((state_q == S_MUL) | (state_q == S_DIV)) cnt_q <= cnt_q - 6'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      op_q  <= Op;
      a_q   <= RsData;
      b_q   <= RtData;
      rem_q <= '0;
      quo_q <= mag32(RsData, Op == OP_DIV);
      dvs_q <= mag32(RtData, Op == OP_DIV);
    end else if (state_q == S_DIV) begin
      if (!trial[33]) begin
        rem_q <= trial[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign Busy    = ~idle;
  assign Stall   = Busy & (ReadReq | Start);
  assign inHigh  = in_high_q;
  assign inLow   = in_low_q;
  assign HIWrite = hi_wr_q;
  assign LOWrite = lo_wr_q;
  assign Done    = done_q;

endmodule
